keypad_scanner: RTL and testbench

Drives the columns of a 4x4 matrix keypad and samples its rows to build a 16-bit pressed-key map. Rows are synchronized, one column is driven per dwell period, and a complete `key_matrix`/`key_detected` pair is published once per frame for the downstream debouncer. When the debouncer raises `scan_stop`, the scanner stops rotating and tracks only the column holding the pressed key, so that release can be detected.

---
 rtl/keypad_pkg.sv | 16 +
 rtl/keypad_row_sync.sv | 12 +
 rtl/keypad_scanner.sv | 81 ++++++++
 tb/tb_keypad_scanner.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared scanner state type, keypad geometry and key-index helpers
package keypad_pkg;
  typedef enum logic {SCAN, HOLD} scanner_state_t;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  function automatic int key_index(input int row, input int col);
    return NUM_ROWS * col + row;
  endfunction
  function automatic logic [1:0] lowest_col(input logic [15:0] m);
    logic [1:0] c_low;
    c_low = 2'd0;
    for (int c = NUM_COLS - 1; c >= 0; c--)
      if (|m[key_index(0, c) +: NUM_ROWS]) c_low = 2'(c);
    return c_low;
  endfunction
endpackage

// File: rtl/keypad_row_sync.sv
// keypad_row_sync: two-flop synchronizer for the four raw rows (clk, rst, row_n in; row_sync out, resets to all-ones)
module keypad_row_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] row_sync
);
  logic [3:0] meta;
  always_ff @(posedge clk)
    if (rst) {row_sync, meta} <= '1;
    else {row_sync, meta} <= {meta, row_n};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scanner (clk, rst, row_n, scan_stop in; col_n, key_matrix, key_detected, frame_done out)
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES = 3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_n,
  input  logic        scan_stop,
  output logic [3:0]  col_n,
  output logic [15:0] key_matrix,
  output logic        key_detected,
  output logic        frame_done
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  scanner_state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0] col_idx, col_idx_d;
  logic [15:0] acc, acc_d, key_matrix_d, nib;
  logic key_detected_d, frame_done_d, boundary;
  logic [3:0] row_sync;
  keypad_row_sync u_sync (
    .clk(clk),
    .rst(rst),
    .row_n(row_n),
    .row_sync(row_sync)
  );
  assign boundary = cnt == CW'(SETTLE_CYCLES - 1);
  always_comb begin
    state_d = state;
    cnt_d = boundary ? '0 : cnt + 1'b1;
    col_idx_d = col_idx;
    acc_d = acc;
    key_matrix_d = key_matrix;
    key_detected_d = key_detected;
    frame_done_d = 1'b0;
    nib = '0;
    nib[4*col_idx +: 4] = ~row_sync;
    if (boundary) begin
      if (state == SCAN && scan_stop && |key_matrix) begin
        state_d = HOLD;
        col_idx_d = lowest_col(key_matrix);
      end else if (state == SCAN) begin
        col_idx_d = col_idx + 1'b1;
        acc_d = col_idx == 2'd3 ? '0 : acc | nib;
        key_matrix_d = col_idx == 2'd3 ? acc | nib : key_matrix;
        key_detected_d = col_idx == 2'd3 ? |(acc | nib) : key_detected;
        frame_done_d = col_idx == 2'd3;
      end else if (!scan_stop) begin
        state_d = SCAN;
        col_idx_d = 2'd0;
        acc_d = '0;
      end else begin
        key_matrix_d = nib;
        key_detected_d = |nib;
        frame_done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= SCAN;
      cnt <= '0;
      col_idx <= 2'd0;
      acc <= '0;
      col_n <= 4'b1110;
      key_matrix <= '0;
      key_detected <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      col_idx <= col_idx_d;
      acc <= acc_d;
      col_n <= ~(4'b1 << col_idx_d);
      key_matrix <= key_matrix_d;
      key_detected <= key_detected_d;
      frame_done <= frame_done_d;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized keypad scanner bench against a frame-level reference model
module tb_keypad_scanner;
  localparam int SC = 4;
  logic clk = 1'b0, rst = 1'b1, scan_stop = 1'b0;
  logic [3:0] row_n, col_n;
  logic [15:0] key_matrix, keys = '0;
  logic key_detected, frame_done;
  int checks = 0, errors = 0;
  logic [3:0] pipe[$];
  logic [3:0] frame[4];
  int tick, mcol;
  bit in_hold, m_kd, m_fd;
  logic [15:0] m_km;
  always #5 clk = ~clk;
  keypad_scanner #(.SETTLE_CYCLES(SC)) dut (
    .clk(clk),
    .rst(rst),
    .row_n(row_n),
    .scan_stop(scan_stop),
    .col_n(col_n),
    .key_matrix(key_matrix),
    .key_detected(key_detected),
    .frame_done(frame_done)
  );
  always_comb begin
    row_n = 4'hf;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[4*c+r] && !col_n[c]) row_n[r] = 1'b0;
  end
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_edge(input logic [3:0] pin, input bit rst_now, input bit stop);
    logic [3:0] seen;
    m_fd = 1'b0;
    if (rst_now) begin
      pipe = '{4'hf, 4'hf};
      tick = 0;
      mcol = 0;
      in_hold = 1'b0;
      m_km = '0;
      m_kd = 1'b0;
      frame = '{default: 4'h0};
      return;
    end
    seen = ~pipe.pop_front();
    pipe.push_back(pin);
    if (tick % SC == SC - 1) begin
      if (!in_hold && stop && m_km != 0) begin
        in_hold = 1'b1;
        for (int c = 3; c >= 0; c--) if (m_km[4*c +: 4] != 0) mcol = c;
        tick = -1;
      end else if (!in_hold) begin
        frame[mcol] = seen;
        if (mcol == 3) begin
          m_km = {frame[3], frame[2], frame[1], frame[0]};
          m_kd = |m_km;
          m_fd = 1'b1;
          frame = '{default: 4'h0};
        end
      end else if (!stop) begin
        in_hold = 1'b0;
        tick = -1;
        frame = '{default: 4'h0};
      end else begin
        m_km = 16'(seen) << (4 * mcol);
        m_kd = |seen;
        m_fd = 1'b1;
      end
    end
    tick++;
    if (!in_hold) mcol = (tick / SC) % 4;
  endtask
  task automatic cyc(input int n);
    logic [3:0] pin, ecol;
    bit rr, ss;
    repeat (n) begin
      @(negedge clk);
      pin = row_n;
      rr = rst;
      ss = scan_stop;
      @(posedge clk);
      model_edge(pin, rr, ss);
      #1;
      ecol = ~(4'b1 << mcol);
      check("col_n", {12'h0, col_n}, {12'h0, ecol});
      check("key_matrix", key_matrix, m_km);
      check("key_detected", {15'h0, key_detected}, {15'h0, m_kd});
      check("frame_done", {15'h0, frame_done}, {15'h0, m_fd});
    end
  endtask
  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(32);
    check("idle_km", key_matrix, 16'h0000);
    keys = 16'h0200;
    cyc(40);
    check("press_r1c2", key_matrix, 16'h0200);
    keys = 16'h0090;
    cyc(40);
    check("press_c1_pair", key_matrix, 16'h0090);
    keys = 16'h0200;
    cyc(40);
    scan_stop = 1'b1;
    cyc(20);
    check("hold_col_n", {12'h0, col_n}, 16'h000b);
    keys = 16'h0201;
    cyc(16);
    check("hold_other_col", key_matrix, 16'h0200);
    keys = 16'h0001;
    cyc(12);
    check("release_km", key_matrix, 16'h0000);
    check("release_kd", {15'h0, key_detected}, 16'h0000);
    scan_stop = 1'b0;
    cyc(16);
    keys = 16'h0200;
    cyc(40);
    scan_stop = 1'b1;
    cyc(12);
    rst = 1'b1;
    cyc(1);
    check("rst_hold_col_n", {12'h0, col_n}, 16'h000e);
    check("rst_hold_km", key_matrix, 16'h0000);
    rst = 1'b0;
    scan_stop = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) keys = 16'($urandom & $urandom & $urandom);
      if ($urandom_range(23) == 0) scan_stop = ~scan_stop;
      rst = $urandom_range(599) == 0;
      cyc(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
